// File: rtl/pipeline_stage_register_if.sv
// Valid/ready handshake bundle between pipeline stages: payload plus control strobes.
// The producer uses the master modport and the consumer uses the slave modport.
interface pipeline_stage_register_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 4
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [CTRL_WIDTH-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipeline_stage_register.sv
// Inter-stage pipeline register with a 2-entry skid buffer, flush/bubble support
// and a saturating back-pressure counter.
module pipeline_stage_register #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 4,
  parameter int CNT_WIDTH  = 16,
  parameter int ZERO_CTRL  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  pipeline_stage_register_if.slave    inIf,
  pipeline_stage_register_if.master   outIf,
  output logic [CNT_WIDTH-1:0]        stall_cycles
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mainData_q, mainData_d;
  logic [CTRL_WIDTH-1:0] mainCtrl_q, mainCtrl_d;
  logic [DATA_WIDTH-1:0] skidData_q, skidData_d;
  logic [CTRL_WIDTH-1:0] skidCtrl_q, skidCtrl_d;
  logic [CNT_WIDTH-1:0]  stallCycles_q, stallCycles_d;

  logic inReady;
  logic outValid;
  logic inFire;
  logic outFire;

  // in_ready comes from the state register alone, so it never depends on out_ready.
  assign inReady  = (state_q != FULL);
  assign outValid = (state_q != EMPTY);
  assign inFire   = inIf.valid & inReady;
  assign outFire  = outValid & outIf.ready;

  assign inIf.ready   = inReady;
  assign outIf.valid  = outValid;
  assign outIf.data   = mainData_q;
  assign outIf.ctrl   = ((ZERO_CTRL != 0) && !outValid) ? '0 : mainCtrl_q;
  assign stall_cycles = stallCycles_q;

  always_comb begin
    state_d    = state_q;
    mainData_d = mainData_q;
    mainCtrl_d = mainCtrl_q;
    skidData_d = skidData_q;
    skidCtrl_d = skidCtrl_q;

    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (inFire) begin
            state_d    = BUSY;
            mainData_d = inIf.data;
            mainCtrl_d = inIf.ctrl;
          end
        end
        BUSY: begin
          if (inFire && outFire) begin
            mainData_d = inIf.data;
            mainCtrl_d = inIf.ctrl;
          end else if (inFire) begin
            state_d    = FULL;
            skidData_d = inIf.data;
            skidCtrl_d = inIf.ctrl;
          end else if (outFire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // The skid entry was accepted after the main one, so it moves up behind it.
          if (outFire) begin
            state_d    = BUSY;
            mainData_d = skidData_q;
            mainCtrl_d = skidCtrl_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    stallCycles_d = stallCycles_q;
    if (outValid && !outIf.ready && !flush && (stallCycles_q != {CNT_WIDTH{1'b1}})) begin
      stallCycles_d = stallCycles_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= EMPTY;
      mainData_q    <= '0;
      mainCtrl_q    <= '0;
      skidData_q    <= '0;
      skidCtrl_q    <= '0;
      stallCycles_q <= '0;
    end else begin
      state_q       <= state_d;
      mainData_q    <= mainData_d;
      mainCtrl_q    <= mainCtrl_d;
      skidData_q    <= skidData_d;
      skidCtrl_q    <= skidCtrl_d;
      stallCycles_q <= stallCycles_d;
    end
  end

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Self-checking bench: queue-based reference model checked every cycle, plus
// directed vectors with hand-computed expectations.
module tb_pipeline_stage_register;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [15:0] stallCycles;
  logic [2:0]  stallCycles5;

  int testsRun    = 0;
  int testsFailed = 0;

  pipeline_stage_register_if #(.DATA_WIDTH(64), .CTRL_WIDTH(4)) inIf ();
  pipeline_stage_register_if #(.DATA_WIDTH(64), .CTRL_WIDTH(4)) outIf ();
  pipeline_stage_register_if #(.DATA_WIDTH(64), .CTRL_WIDTH(4)) inIf5 ();
  pipeline_stage_register_if #(.DATA_WIDTH(64), .CTRL_WIDTH(4)) outIf5 ();

  pipeline_stage_register #(
    .DATA_WIDTH(64), .CTRL_WIDTH(4), .CNT_WIDTH(16), .ZERO_CTRL(1)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .inIf(inIf), .outIf(outIf), .stall_cycles(stallCycles)
  );

  // Narrow counter and ZERO_CTRL=0 variant for saturation and raw-ctrl checks.
  pipeline_stage_register #(
    .DATA_WIDTH(64), .CTRL_WIDTH(4), .CNT_WIDTH(3), .ZERO_CTRL(0)
  ) dut5 (
    .clk(clk), .reset(reset), .flush(1'b0),
    .inIf(inIf5), .outIf(outIf5), .stall_cycles(stallCycles5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic [3:0]  c;
  } entry_t;

  entry_t      mq[$];
  logic [15:0] mStall;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [63:0] d, input logic [3:0] c,
                               input logic r, input logic f);
    inIf.valid  = v;
    inIf.data   = d;
    inIf.ctrl   = c;
    outIf.ready = r;
    flush       = f;
    @(posedge clk);
    #1;
  endtask

  // Reference model: the stage is a FIFO of at most two entries in acceptance order.
  always @(posedge clk or posedge reset) begin
    bit inF;
    bit outF;
    if (reset) begin
      mq.delete();
      mStall = '0;
    end else begin
      inF  = inIf.valid && (mq.size() < 2);
      outF = (mq.size() > 0) && outIf.ready;
      if ((mq.size() > 0) && !outIf.ready && !flush && (mStall != 16'hFFFF)) mStall++;
      if (flush) begin
        mq.delete();
      end else begin
        if (outF) void'(mq.pop_front());
        if (inF) mq.push_back('{d: inIf.data, c: inIf.ctrl});
      end
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      checkOutput("rst_out_valid", {63'd0, outIf.valid}, 64'd0);
      checkOutput("rst_in_ready", {63'd0, inIf.ready}, 64'd1);
      checkOutput("rst_out_data", outIf.data, 64'd0);
      checkOutput("rst_out_ctrl", {60'd0, outIf.ctrl}, 64'd0);
      checkOutput("rst_stall", {48'd0, stallCycles}, 64'd0);
    end else begin
      checkOutput("mdl_out_valid", {63'd0, outIf.valid}, {63'd0, mq.size() > 0});
      checkOutput("mdl_in_ready", {63'd0, inIf.ready}, {63'd0, mq.size() < 2});
      if (mq.size() > 0) begin
        checkOutput("mdl_out_data", outIf.data, mq[0].d);
        checkOutput("mdl_out_ctrl", {60'd0, outIf.ctrl}, {60'd0, mq[0].c});
      end else begin
        checkOutput("mdl_out_ctrl_zero", {60'd0, outIf.ctrl}, 64'd0);
      end
      checkOutput("mdl_stall", {48'd0, stallCycles}, {48'd0, mStall});
    end
  end

  initial begin
    reset        = 1'b1;
    flush        = 1'b0;
    inIf.valid   = 1'b0;
    inIf.data    = '0;
    inIf.ctrl    = '0;
    outIf.ready  = 1'b0;
    inIf5.valid  = 1'b0;
    inIf5.data   = '0;
    inIf5.ctrl   = '0;
    outIf5.ready = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;

    // Streaming at full rate with one-cycle latency.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 64'(i), 4'(i), 1'b1, 1'b0);
      checkOutput("t2_valid", {63'd0, outIf.valid}, 64'd1);
      checkOutput("t2_data", outIf.data, 64'(i));
      checkOutput("t2_in_ready", {63'd0, inIf.ready}, 64'd1);
    end
    applyStimulus(1'b0, 64'd0, 4'd0, 1'b1, 1'b0);
    checkOutput("t2_drained", {63'd0, outIf.valid}, 64'd0);

    // Back-pressure fills the skid, then releases in order.
    applyStimulus(1'b1, 64'hA, 4'h1, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'hB, 4'h2, 1'b0, 1'b0);
    checkOutput("t3_full_in_ready", {63'd0, inIf.ready}, 64'd0);
    checkOutput("t3_stall1", {48'd0, stallCycles}, 64'd1);
    applyStimulus(1'b1, 64'hC, 4'h3, 1'b0, 1'b0);
    checkOutput("t3_held_data", outIf.data, 64'hA);
    checkOutput("t3_stall2", {48'd0, stallCycles}, 64'd2);
    applyStimulus(1'b1, 64'hC, 4'h3, 1'b1, 1'b0);
    checkOutput("t3_second", outIf.data, 64'hB);
    checkOutput("t3_ctrl_b", {60'd0, outIf.ctrl}, 64'h2);
    applyStimulus(1'b1, 64'hC, 4'h3, 1'b1, 1'b0);
    checkOutput("t3_third", outIf.data, 64'hC);
    applyStimulus(1'b0, 64'd0, 4'd0, 1'b1, 1'b0);
    checkOutput("t3_empty", {63'd0, outIf.valid}, 64'd0);
    checkOutput("t3_stall_final", {48'd0, stallCycles}, 64'd2);

    // Flush while full, with a new entry offered the same cycle.
    applyStimulus(1'b1, 64'hA, 4'hF, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'hB, 4'hF, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'hC, 4'hF, 1'b0, 1'b1);
    checkOutput("t4_valid", {63'd0, outIf.valid}, 64'd0);
    checkOutput("t4_ctrl", {60'd0, outIf.ctrl}, 64'd0);
    checkOutput("t4_in_ready", {63'd0, inIf.ready}, 64'd1);
    checkOutput("t4_stall", {48'd0, stallCycles}, 64'd3);
    applyStimulus(1'b0, 64'd0, 4'd0, 1'b1, 1'b0);
    checkOutput("t4_no_c", {63'd0, outIf.valid}, 64'd0);

    // Asynchronous reset while full.
    applyStimulus(1'b1, 64'hA, 4'h5, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'hB, 4'h6, 1'b0, 1'b0);
    checkOutput("t1_pre_in_ready", {63'd0, inIf.ready}, 64'd0);
    checkOutput("t1_pre_stall", {48'd0, stallCycles}, 64'd4);
    inIf.valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checkOutput("t1_valid", {63'd0, outIf.valid}, 64'd0);
    checkOutput("t1_in_ready", {63'd0, inIf.ready}, 64'd1);
    checkOutput("t1_ctrl", {60'd0, outIf.ctrl}, 64'd0);
    checkOutput("t1_stall", {48'd0, stallCycles}, 64'd0);
    checkOutput("t1_data", outIf.data, 64'd0);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;

    // Random traffic; the per-cycle model comparison catches loss, duplication and reordering.
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), {$urandom, $urandom}, 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
    end
    applyStimulus(1'b0, 64'd0, 4'd0, 1'b1, 1'b0);
    applyStimulus(1'b0, 64'd0, 4'd0, 1'b1, 1'b0);
    checkOutput("t6_drained", {63'd0, outIf.valid}, 64'd0);

    // Saturation of a 3-bit counter, and raw ctrl visibility with ZERO_CTRL=0.
    inIf5.valid  = 1'b1;
    inIf5.data   = 64'h55;
    inIf5.ctrl   = 4'h9;
    outIf5.ready = 1'b0;
    @(posedge clk);
    #1;
    inIf5.valid = 1'b0;
    checkOutput("t5_valid", {63'd0, outIf5.valid}, 64'd1);
    checkOutput("t5_stall0", {61'd0, stallCycles5}, 64'd0);
    for (int k = 2; k <= 11; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) checkOutput("t5_stall4", {61'd0, stallCycles5}, 64'd4);
    end
    checkOutput("t5_stall_sat", {61'd0, stallCycles5}, 64'd7);
    outIf5.ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t5_drained", {63'd0, outIf5.valid}, 64'd0);
    checkOutput("t5_raw_ctrl", {60'd0, outIf5.ctrl}, 64'h9);
    checkOutput("t5_stall_hold", {61'd0, stallCycles5}, 64'd7);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
